// File: rtl/sr_ff_arbiter.sv
// rtl/sr_ff_arbiter.sv - round-robin arbiter giving N requesters turns at driving one shared sr_ff
// Each grant issues one set/reset pulse, then waits for q_fb to confirm the commanded value.
module sr_ff_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] op,
  output logic [N-1:0] grant,
  output logic [N-1:0] ack,
  output logic         s,
  output logic         r,
  input  logic         q_fb,
  output logic         err,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] ptr_next;
  logic          found;
  logic          lop;
  logic [3:0]    cnt;
  logic [N-1:0]  win_onehot;
  int            idx;

  // Walk downward so the last hit, i.e. the one nearest ptr, wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign ptr_next   = (win == IW'(N - 1)) ? '0 : win + 1'b1;
  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      ack   <= '0;
      s     <= 1'b0;
      r     <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      lop   <= 1'b0;
      cnt   <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant <= win_onehot;
            lop   <= op[win];
            s     <= op[win];
            r     <= ~op[win];
            busy  <= 1'b1;
            ptr   <= ptr_next;
            cnt   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          s     <= 1'b0;
          r     <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == lop) begin
            ack   <= grant;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 4'(TIMEOUT - 1)) begin
            // Give up: release the owner anyway so arbitration keeps moving.
            err   <= 1'b1;
            ack   <= grant;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
          s     <= 1'b0;
          r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sr_ff_arbiter.md
SR_FF_ARBITER -- requirements
Module: sr_ff_arbiter

Interface
REQ-001 Parameter: N, default 4, number of requesters sharing one sr_ff; legal range 2..8.
REQ-002 Parameter: TIMEOUT, default 3, CHECK-state cycles allowed for q_fb to match before error; legal range 1..15.
REQ-003 Ports: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Ports: rst  input  1  reset, synchronous, active-high.
REQ-005 Ports: req  input  N  per-requester request, level; held until ack.
REQ-006 Ports: op  input  N  per-requester operation, 1=set, 0=reset; sampled at grant.
REQ-007 Ports: grant  output  N  one-hot owner of the sr_ff; all-zero when idle.
REQ-008 Ports: ack  output  N  one-cycle completion pulse to the granted requester.
REQ-009 Ports: s  output  1  set drive to the shared sr_ff.
REQ-010 Ports: r  output  1  reset drive to the shared sr_ff.
REQ-011 Ports: q_fb  input  1  q output of the shared sr_ff.
REQ-012 Ports: err  output  1  sticky error, q_fb failed to reach the commanded value.
REQ-013 Ports: busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, ISSUE, CHECK; all outputs registered.
REQ-015 IDLE: if any req bit high, select winner by round-robin, latch winner index and op[winner], assert grant one-hot, go to ISSUE next cycle.
REQ-016 Round-robin: search starts at index ptr; ptr resets to 0 and becomes winner+1 (mod N) on each grant.
REQ-017 ISSUE: exactly one cycle; s=latched op, r=~latched op; go to CHECK.
REQ-018 s and r shall never both be 1 in any cycle, including reset and error cycles.
REQ-019 CHECK: s=r=0; each cycle compare q_fb with latched op; match -> pulse ack[winner] one cycle, clear grant, go to IDLE.
REQ-020 CHECK mismatch for TIMEOUT consecutive cycles -> set err, pulse ack[winner], clear grant, go to IDLE.
REQ-021 err remains set until rst; arbitration continues normally while err is set.
REQ-022 Grant-to-ack latency: 2 cycles minimum (ISSUE + one CHECK cycle), TIMEOUT+1 maximum.
REQ-023 One transaction at a time; a new grant is not issued in the cycle ack pulses; earliest next grant is the cycle after return to IDLE.
REQ-024 req deasserted by the owner after grant is ignored; the transaction completes and ack still pulses.
REQ-025 Changes to op after grant are ignored.
REQ-026 Same requester re-requesting immediately is served only after all other pending requesters (fairness bound N transactions).
REQ-027 busy=1 in ISSUE and CHECK, 0 in IDLE.

Reset
REQ-028 rst high at a clock edge: state=IDLE, ptr=0, grant=0, ack=0, s=0, r=0, err=0, busy=0, effective next cycle.
REQ-029 rst mid-transaction (ISSUE or CHECK) aborts it without ack; s and r go to 0.
REQ-030 rst has priority over every other condition in the same cycle.

Verification
REQ-031 rst=1 for 2 cycles then 0, req=0 -> grant=0, ack=0, s=r=0, err=0, busy=0.
REQ-032 req=0001, op=0001, sr_ff model connected -> grant=0001 next cycle, s=1 for one cycle, ack[0] pulse two cycles after grant, q_fb=1, err=0.
REQ-033 req=1111 held, ops alternating -> grants in order 0001,0010,0100,1000,0001; s&r never both 1; each ack matches grant.
REQ-034 req=0010, op=0, q_fb stuck at 1 -> after TIMEOUT=3 CHECK cycles err=1 and ack[1] pulses; err stays 1 through later good transactions until rst.
REQ-035 rst asserted during CHECK of a grant to requester 2 -> no ack[2], grant=0, s=r=0, ptr=0 next cycle.
REQ-036 req[3] deasserted one cycle after grant=1000 -> ack[3] still pulses; next grant goes to the next pending requester.
